tero_collector: RTL

//  Sequencer and harvester placed directly around tero_rng.
//  - Drives tero_rng.CTR: holds it low to reset the ring, then raises it to start one oscillation trial.
//  - Waits for tero_rng.OE, captures OUT and takes bit 0 of each valid trial as one raw random bit.
//  - Packs 8 bits into a byte and queues it in a FIFO with a valid/ready output toward the UART/host stage.

---
 rtl/tero_collector_pkg.sv | 6 +
 rtl/tero_byte_fifo.sv | 38 +++
 rtl/tero_collector.sv | 110 +++++++++++
 3 files changed

// File: rtl/tero_collector_pkg.sv
// tero_collector_pkg: FSM state encoding and tero_rng constants shared by the collector files.
package tero_collector_pkg;
   typedef enum logic [1:0] {ST_LOW = 2'd0, ST_HIGH = 2'd1, ST_CAPT = 2'd2} state_t;
   localparam logic [7:0] RNG_SATURATED = 8'hff;
   localparam int OE_MAX_DELAY = 200;
endpackage

// File: rtl/tero_byte_fifo.sv
// tero_byte_fifo: first-word-fall-through FIFO; the head entry drives DOUT directly from storage.
module tero_byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             CLK_100M,
   input  logic             RST_N,
   input  logic             PUSH,
   input  logic [WIDTH-1:0] DIN,
   output logic             FULL,
   output logic [WIDTH-1:0] DOUT,
   output logic             DOUT_VALID,
   input  logic             DOUT_READY
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wptr, rptr;
   logic pop;
   assign DOUT_VALID = wptr != rptr;
   assign FULL = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign pop = DOUT_VALID && DOUT_READY;
   assign DOUT = mem[rptr[AW-1:0]];
   always_ff @(posedge CLK_100M or negedge RST_N) begin
      if (!RST_N) begin
         wptr <= '0;
         rptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (PUSH) begin
            mem[wptr[AW-1:0]] <= DIN;
            wptr <= wptr + 1'b1;
         end
         if (pop) rptr <= rptr + 1'b1;
      end
   end
   // the collector only starts a trial when there is room, so this must never fire
   assert property (@(posedge CLK_100M) disable iff (!RST_N) !(PUSH && FULL));
endmodule

// File: rtl/tero_collector.sv
// tero_collector: sequences tero_rng trials, packs bit 0 of each valid count LSB-first into bytes.
// Define TERO_COLLECTOR_VN_EN to pass accepted bits through a von Neumann debiaser first.
module tero_collector
   import tero_collector_pkg::*;
#(
   parameter int LOW_CYCLES = 16,
   parameter int TIMEOUT    = 255,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        CLK_100M,
   input  logic        RST_N,
   output logic        CTR,
   input  logic [7:0]  RNG_OUT,
   input  logic        RNG_OE,
   output logic [7:0]  DOUT,
   output logic        DOUT_VALID,
   input  logic        DOUT_READY,
   output logic [15:0] ERR_CNT
);
   if (TIMEOUT <= OE_MAX_DELAY + 3) begin : g_timeout_chk
      $error("tero_collector: TIMEOUT must exceed OE_MAX_DELAY + 3");
   end
   localparam logic [9:0] LOW_LAST = 10'(LOW_CYCLES - 1);
   localparam logic [9:0] TO_LAST  = 10'(TIMEOUT - 1);
   state_t state;
   logic [9:0] cnt;
   logic [7:0] rng_q, pack;
   logic [2:0] bit_cnt;
   logic [15:0] err_cnt;
   logic full, bit_ok, bit_val, push, err_inc, saturated;
   assign saturated = rng_q == RNG_SATURATED;
`ifdef TERO_COLLECTOR_VN_EN
   logic pend, have_pend;
   always_ff @(posedge CLK_100M or negedge RST_N) begin
      if (!RST_N) begin
         pend <= 1'b0;
         have_pend <= 1'b0;
      end else if (state == ST_CAPT && !saturated) begin
         pend <= rng_q[0];
         have_pend <= !have_pend;
      end
   end
   // a differing pair emits its first bit; equal pairs emit nothing
   assign bit_ok = !saturated && have_pend && (pend != rng_q[0]);
   assign bit_val = pend;
`else
   assign bit_ok = !saturated;
   assign bit_val = rng_q[0];
`endif
   assign push = (state == ST_CAPT) && bit_ok && (bit_cnt == 3'd7);
   assign err_inc = (state == ST_HIGH && !RNG_OE && cnt == TO_LAST) || (state == ST_CAPT && saturated);
   assign ERR_CNT = err_cnt;
   always_ff @(posedge CLK_100M or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_LOW;
         CTR <= 1'b0;
         cnt <= '0;
         rng_q <= '0;
         pack <= '0;
         bit_cnt <= '0;
      end else begin
         case (state)
            ST_LOW:
               if (cnt != LOW_LAST) cnt <= cnt + 10'd1;
               else if (!full) begin
                  state <= ST_HIGH;
                  CTR <= 1'b1;
                  cnt <= '0;
               end
            ST_HIGH:
               if (RNG_OE) begin
                  state <= ST_CAPT;
                  CTR <= 1'b0;
                  rng_q <= RNG_OUT;
               end else if (cnt == TO_LAST) begin
                  state <= ST_LOW;
                  CTR <= 1'b0;
                  cnt <= '0;
               end else cnt <= cnt + 10'd1;
            ST_CAPT: begin
               state <= ST_LOW;
               cnt <= '0;
               if (bit_ok) begin
                  pack <= {bit_val, pack[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end
            default: begin
               state <= ST_LOW;
               CTR <= 1'b0;
               cnt <= '0;
            end
         endcase
      end
   end
   always_ff @(posedge CLK_100M or negedge RST_N) begin
      if (!RST_N) err_cnt <= '0;
      else if (err_inc && err_cnt != 16'hffff) err_cnt <= err_cnt + 16'd1;
   end
   tero_byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .CLK_100M   (CLK_100M),
      .RST_N      (RST_N),
      .PUSH       (push),
      .DIN        ({bit_val, pack[7:1]}),
      .FULL       (full),
      .DOUT       (DOUT),
      .DOUT_VALID (DOUT_VALID),
      .DOUT_READY (DOUT_READY)
   );
endmodule
